// File: rtl/counter_x.sv
// Three-channel 32-bit down-counter/timer with a shared control register.
// Each channel supports one-shot, periodic-pulse and square-wave modes.
module counter_x (
  input  logic        clk,
  input  logic        rst,
  input  logic        counter_we,
  input  logic [1:0]  counter_ch,
  input  logic [31:0] counter_val,
  output logic        counter0_out,
  output logic        counter1_out,
  output logic        counter2_out,
  output logic [31:0] counter_out
);

  // state | meaning
  // IDLE  | no reload loaded (or reload 0); out held at 0
  // COUNT | decrementing toward terminal count
  // DONE  | one-shot expired; out held at 1, count held at 0
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_SQUARE   = 2'b10;
  localparam logic [1:0] MODE_RSVD     = 2'b11;
  localparam logic [1:0] SEL_CTRL      = 2'b11;

  logic [11:0] ctrl_q, ctrl_d;
  logic [31:0] reload_q [3];
  logic [31:0] reload_d [3];
  logic [31:0] count_q  [3];
  logic [31:0] count_d  [3];
  logic [2:0]  out_q, out_d;
  state_t      state_q  [3];
  state_t      state_d  [3];
  logic [1:0]  mode     [3];
  logic        en       [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q <= '0;
      out_q  <= '0;
      for (int n = 0; n < 3; n++) begin
        reload_q[n] <= '0;
        count_q[n]  <= '0;
        state_q[n]  <= IDLE;
      end
    end else begin
      ctrl_q <= ctrl_d;
      out_q  <= out_d;
      for (int n = 0; n < 3; n++) begin
        reload_q[n] <= reload_d[n];
        count_q[n]  <= count_d[n];
        state_q[n]  <= state_d[n];
      end
    end
  end

  always_comb begin
    ctrl_d = ctrl_q;
    out_d  = out_q;
    if (counter_we && counter_ch == SEL_CTRL)
      ctrl_d = counter_val[11:0];

    for (int n = 0; n < 3; n++) begin
      reload_d[n] = reload_q[n];
      count_d[n]  = count_q[n];
      state_d[n]  = state_q[n];
      mode[n]     = ctrl_q[4*n +: 2];
      en[n]       = ctrl_q[4*n + 2];

      // A reload write wins over any count/terminal action this cycle.
      if (counter_we && counter_ch == 2'(n)) begin
        reload_d[n] = counter_val;
        count_d[n]  = counter_val;
        out_d[n]    = 1'b0;
        state_d[n]  = (counter_val != '0) ? COUNT : IDLE;
      end else begin
        case (state_q[n])
          COUNT: begin
            if (en[n] && mode[n] != MODE_RSVD) begin
              if (count_q[n] > 32'd1) begin
                count_d[n] = count_q[n] - 32'd1;
                if (mode[n] == MODE_PERIODIC)
                  out_d[n] = 1'b0;
              end else if (count_q[n] == 32'd1) begin
                case (mode[n])
                  MODE_ONESHOT: begin
                    count_d[n] = '0;
                    out_d[n]   = 1'b1;
                    state_d[n] = DONE;
                  end
                  MODE_PERIODIC: begin
                    count_d[n] = reload_q[n];
                    out_d[n]   = 1'b1;
                  end
                  MODE_SQUARE: begin
                    count_d[n] = reload_q[n];
                    out_d[n]   = ~out_q[n];
                  end
                  default: ;
                endcase
              end
            end
          end
          DONE: begin
            count_d[n] = '0;
            out_d[n]   = 1'b1;
          end
          default: out_d[n] = 1'b0;
        endcase
      end
    end
  end

  always_comb begin
    counter_out = '0;
    case (counter_ch)
      2'd0:    counter_out = count_q[0];
      2'd1:    counter_out = count_q[1];
      2'd2:    counter_out = count_q[2];
      default: counter_out = {20'b0, ctrl_q};
    endcase
  end

  assign counter0_out = out_q[0];
  assign counter1_out = out_q[1];
  assign counter2_out = out_q[2];

endmodule

// File: tb/tb_counter_x.sv
// Directed bench for counter_x: expectations are queued as stimulus is driven
// and popped against the DUT outputs one cycle later.
module tb_counter_x;
  logic        clk = 1'b0;
  logic        rst;
  logic        counter_we;
  logic [1:0]  counter_ch;
  logic [31:0] counter_val;
  logic        counter0_out, counter1_out, counter2_out;
  logic [31:0] counter_out;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_q [$];
  logic [1:0]  rd_sel;

  always #5 clk = ~clk;

  counter_x dut (
    .clk(clk), .rst(rst), .counter_we(counter_we), .counter_ch(counter_ch),
    .counter_val(counter_val), .counter0_out(counter0_out),
    .counter1_out(counter1_out), .counter2_out(counter2_out),
    .counter_out(counter_out)
  );

  function automatic logic [31:0] outs();
    return {29'd0, counter2_out, counter1_out, counter0_out};
  endfunction

  function automatic logic [31:0] out_of(input int n);
    logic [2:0] v;
    v = {counter2_out, counter1_out, counter0_out};
    return {31'd0, v[n]};
  endfunction

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s: scoreboard empty, observed=%0h", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input logic [1:0] ch);
    rd_sel     = ch;
    counter_ch = ch;
    #1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [31:0] val);
    counter_we  = 1'b1;
    counter_ch  = ch;
    counter_val = val;
    step();
    counter_we  = 1'b0;
    counter_ch  = rd_sel;
    #1;
  endtask

  // Queue count/out expectations for channel n, advance one edge, compare.
  task automatic exp_step(input string tag, input int n, input logic [31:0] c, input logic o);
    push(c);
    push({31'd0, o});
    step();
    chk({tag, "_c"}, counter_out);
    chk({tag, "_o"}, out_of(n));
  endtask

  // Same, but the advancing edge carries a write.
  task automatic exp_wr(input string tag, input int n, input logic [1:0] ch,
                        input logic [31:0] val, input logic [31:0] c, input logic o);
    push(c);
    push({31'd0, o});
    wr(ch, val);
    chk({tag, "_c"}, counter_out);
    chk({tag, "_o"}, out_of(n));
  endtask

  initial begin
    rst = 1'b1; counter_we = 1'b0; counter_ch = 2'd0; counter_val = '0; rd_sel = 2'd0;
    #12;
    for (int ch = 0; ch < 4; ch++) begin
      sel(2'(ch));
      push(32'd0);
      chk("rst_rd", counter_out);
    end
    push(32'd0);
    chk("rst_outs", outs());
    step();
    rst = 1'b0;

    // one-shot on ch0, upper control bits ignored
    sel(2'd3);
    wr(2'd3, 32'hABCD_E004);
    push(32'h004);
    chk("ctrl_rd", counter_out);
    sel(2'd0);
    exp_wr("s1_k", 0, 2'd0, 32'd5, 32'd5, 1'b0);
    for (int j = 1; j <= 7; j++)
      exp_step("s1", 0, (j < 5) ? 32'(5 - j) : 32'd0, j >= 5);

    // periodic on ch1, reload 3
    wr(2'd3, 32'h050);
    sel(2'd1);
    exp_wr("s2_k", 1, 2'd1, 32'd3, 32'd3, 1'b0);
    for (int j = 1; j <= 9; j++)
      exp_step("s2", 1, 32'(3 - (j % 3)), (j % 3) == 0);

    // square on ch2, reload 2; ch1 gets one more edge then freezes
    wr(2'd3, 32'h600);
    sel(2'd2);
    exp_wr("s3_k", 2, 2'd2, 32'd2, 32'd2, 1'b0);
    for (int j = 1; j <= 8; j++)
      exp_step("s3", 2, 32'(2 - (j % 2)), ((j / 2) % 2) == 1);
    sel(2'd1);
    push(32'd2);
    chk("s3_ch1_hold_c", counter_out);
    push(32'd0);
    chk("s3_ch1_hold_o", out_of(1));

    // enable pause: C held at 4 for three edges, then resumes
    wr(2'd3, 32'h004);
    sel(2'd0);
    exp_wr("s4_k", 0, 2'd0, 32'd5, 32'd5, 1'b0);
    exp_wr("s4_dis", 0, 2'd3, 32'h000, 32'd4, 1'b0);
    exp_step("s4_p1", 0, 32'd4, 1'b0);
    exp_step("s4_p2", 0, 32'd4, 1'b0);
    exp_wr("s4_en", 0, 2'd3, 32'h004, 32'd4, 1'b0);
    exp_step("s4_r3", 0, 32'd3, 1'b0);
    exp_step("s4_r2", 0, 32'd2, 1'b0);
    exp_step("s4_r1", 0, 32'd1, 1'b0);
    exp_step("s4_tc", 0, 32'd0, 1'b1);

    // reload coinciding with terminal count
    exp_wr("s5_k", 0, 2'd0, 32'd2, 32'd2, 1'b0);
    exp_step("s5_c1", 0, 32'd1, 1'b0);
    exp_wr("s5_prio", 0, 2'd0, 32'd7, 32'd7, 1'b0);
    exp_step("s5_after", 0, 32'd6, 1'b0);

    // async reset mid-count
    wr(2'd3, 32'h654);
    wr(2'd1, 32'd4);
    sel(2'd2);
    exp_wr("s5_sq_k", 2, 2'd2, 32'd1, 32'd1, 1'b0);
    exp_step("s5_sq_t", 2, 32'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    push(32'd0);
    chk("rst_mid_outs", outs());
    for (int ch = 0; ch < 4; ch++) begin
      sel(2'(ch));
      push(32'd0);
      chk("rst_mid_rd", counter_out);
    end
    step();
    step();
    rst = 1'b0;
    sel(2'd0);
    wr(2'd3, 32'h654);
    for (int j = 0; j < 4; j++) begin
      push(32'd0);
      push(32'd0);
      step();
      chk("post_rst_c0", counter_out);
      chk("post_rst_outs", outs());
    end

    // reload 0 stays idle
    exp_wr("s6_z", 0, 2'd0, 32'd0, 32'd0, 1'b0);
    for (int j = 0; j < 4; j++)
      exp_step("s6_idle", 0, 32'd0, 1'b0);

    // reserved mode freezes, switching back resumes from held count
    wr(2'd3, 32'h657);
    exp_wr("s6_m3_k", 0, 2'd0, 32'd9, 32'd9, 1'b0);
    for (int j = 0; j < 4; j++)
      exp_step("s6_m3", 0, 32'd9, 1'b0);
    exp_wr("s6_mchg", 0, 2'd3, 32'h654, 32'd9, 1'b0);
    exp_step("s6_res8", 0, 32'd8, 1'b0);
    exp_step("s6_res7", 0, 32'd7, 1'b0);

    // periodic N=1 holds out high
    sel(2'd1);
    exp_wr("s7_k", 1, 2'd1, 32'd1, 32'd1, 1'b0);
    for (int j = 0; j < 4; j++)
      exp_step("s7_n1", 1, 32'd1, 1'b1);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_leftover: observed=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
